mult_accum: RTL and testbench

MULT_ACCUM -- requirements
Module: mult_accum

---
 rtl/mult_accum_pkg.sv | 14 +
 rtl/rca.sv | 25 ++
 rtl/mult_accum.sv | 125 ++++++++++++
 tb/tb_mult_accum.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_accum_pkg.sv
// Shared types and default widths for the multiply-accumulate block.
package mult_accum_pkg;

    localparam int unsigned PROD_W_DEF = 16;
    localparam int unsigned ACC_W_DEF  = 20;
    localparam int unsigned CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/rca.sv
// Ripple-carry adder: W-bit sum with carry-in and carry-out.
module rca #(
    parameter int unsigned W = 20
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic carry;

    // Full-adder chain, LSB first.
    always_comb begin
        carry = cin;
        sum   = '0;
        for (int i = 0; i < int'(W); i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/mult_accum.sv
// Saturating accumulator for a fixed-length burst of multiplier products.
module mult_accum
    import mult_accum_pkg::*;
#(
    parameter int unsigned PROD_W = PROD_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              in_valid,
    input  logic [PROD_W-1:0] in_prod,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              busy
);

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [CNT_W-1:0] remaining;
    logic [ACC_W-1:0] add_sum;
    logic             add_cout;
    logic             accept;

    // A product is taken only while accumulating and the producer is valid.
    assign accept = (state == ST_ACCUM) && in_valid;

    // Accumulator adder; its carry-out is the saturation flag.
    rca #(
        .W (ACC_W)
    ) u_rca (
        .a    (acc),
        .b    (ACC_W'(in_prod)),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (len != '0) ? ST_ACCUM : ST_DONE;
                end
            end
            ST_ACCUM: begin
                if (accept && (remaining == CNT_W'(1))) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode straight from registered state and datapath.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        out_sum   = acc;
        out_ovf   = ovf;
        case (state)
            ST_ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: clear on accepted start, saturating add on each accepted product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            ovf       <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc       <= '0;
                        ovf       <= 1'b0;
                        remaining <= len;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        acc       <= add_cout ? '1 : add_sum;
                        ovf       <= ovf | add_cout;
                        remaining <= remaining - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_accum.sv
// Randomized self-checking bench for mult_accum against a sum/clamp model.
module tb_mult_accum;

    localparam int unsigned PROD_W = 16;
    localparam int unsigned ACC_W  = 20;
    localparam int unsigned CNT_W  = 8;
    localparam longint unsigned ACC_MAX = (64'd1 << ACC_W) - 64'd1;

    logic              clk;
    logic              reset;
    logic              start;
    logic [CNT_W-1:0]  len;
    logic              in_valid;
    logic [PROD_W-1:0] in_prod;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;
    logic              busy;

    int n_checks;
    int n_fail;
    logic [PROD_W-1:0] q[$];

    mult_accum #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_prod   (in_prod),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Everything the block drives must be zero while reset holds it.
    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},  64'(in_ready),  0);
        check({tag, "_out_valid"}, 64'(out_valid), 0);
        check({tag, "_busy"},      64'(busy),      0);
        check({tag, "_out_sum"},   64'(out_sum),   0);
        check({tag, "_out_ovf"},   64'(out_ovf),   0);
    endtask

    // One complete burst of the products in q; result is the clamped total.
    task automatic run_txn(input int gap_max, input int hold);
        int n;
        int g;
        longint unsigned total;
        longint unsigned exp_sum;
        longint unsigned exp_ovf;
        n = q.size();
        total = 0;
        foreach (q[i]) total += 64'(q[i]);
        exp_ovf = (total > ACC_MAX) ? 1 : 0;
        exp_sum = (total > ACC_MAX) ? ACC_MAX : total;

        @(negedge clk);
        check("idle_busy",      64'(busy),      0);
        check("idle_in_ready",  64'(in_ready),  0);
        check("idle_out_valid", 64'(out_valid), 0);
        start    = 1'b1;
        len      = CNT_W'(n);
        in_valid = 1'($urandom);
        in_prod  = PROD_W'($urandom);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;

        for (int i = 0; i < n; i++) begin
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) begin
                check("stall_in_ready",  64'(in_ready),  1);
                check("stall_out_valid", 64'(out_valid), 0);
                in_valid = 1'b0;
                in_prod  = PROD_W'($urandom);
                @(negedge clk);
            end
            check("accum_in_ready", 64'(in_ready), 1);
            check("accum_busy",     64'(busy),     1);
            in_valid = 1'b1;
            in_prod  = q[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_prod  = PROD_W'($urandom);

        check("done_out_valid", 64'(out_valid), 1);
        check("done_in_ready",  64'(in_ready),  0);
        check("done_busy",      64'(busy),      1);
        check("done_sum",       64'(out_sum),   exp_sum);
        check("done_ovf",       64'(out_ovf),   exp_ovf);

        repeat (hold) begin
            out_ready = 1'b0;
            start     = 1'($urandom);
            len       = CNT_W'($urandom);
            in_valid  = 1'($urandom);
            @(negedge clk);
            check("hold_out_valid", 64'(out_valid), 1);
            check("hold_sum",       64'(out_sum),   exp_sum);
            check("hold_ovf",       64'(out_ovf),   exp_ovf);
        end

        // Handoff cycle: start presented alongside out_ready must be dropped.
        out_ready = 1'b1;
        start     = 1'b1;
        len       = CNT_W'(3);
        in_valid  = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        check("release_out_valid", 64'(out_valid), 0);
        check("release_busy",      64'(busy),      0);
        @(negedge clk);
        check("handoff_busy",      64'(busy),      0);
        check("handoff_in_ready",  64'(in_ready),  0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b0;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_prod   = '0;
        out_ready = 1'b0;

        #2 reset = 1'b1;
        #1 check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Three small products back to back.
        q = '{16'h0010, 16'h0020, 16'h0030};
        run_txn(0, 0);

        // Zero-length request.
        q = {};
        run_txn(0, 2);

        // Saturation, then a fresh burst clears the flag.
        q = {};
        repeat (17) q.push_back(16'hFFFF);
        run_txn(0, 1);
        q = '{16'h0001};
        run_txn(0, 0);

        // Gapped input and a long hold in DONE.
        q = '{PROD_W'($urandom), PROD_W'($urandom)};
        run_txn(3, 5);

        // Reset in the middle of a burst discards it.
        @(negedge clk);
        start = 1'b1;
        len   = CNT_W'(4);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_prod  = 16'h1234;
        @(negedge clk);
        in_prod  = 16'h4321;
        @(negedge clk);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1 check_all_zero("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        q = '{16'h0005};
        run_txn(0, 0);

        // Random bursts, some biased toward saturation.
        for (int t = 0; t < 14; t++) begin
            int n;
            bit big;
            n   = int'($urandom_range(20, 0));
            big = ($urandom_range(2, 0) == 0);
            q = {};
            for (int k = 0; k < n; k++) begin
                if (big) q.push_back(PROD_W'($urandom_range(65535, 50000)));
                else     q.push_back(PROD_W'($urandom));
            end
            run_txn(int'($urandom_range(3, 0)), int'($urandom_range(4, 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
